// File: rtl/keypad_scan_if.sv
// Keypad scan controller bus: matrix drive/sense plus the key FIFO consumer handshake.
// master = controller side, slave = keypad/consumer side.
interface keypad_scan_if;
    logic [3:0] col_out;
    logic [3:0] row_in;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic       key_held;
    logic [2:0] fifo_count;
    logic       overflow;

    modport master (
        output col_out, key_code, key_valid, key_held, fifo_count, overflow,
        input  row_in, key_ready
    );

    modport slave (
        input  col_out, key_code, key_valid, key_held, fifo_count, overflow,
        output row_in, key_ready
    );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: column scan, whole-scan debounce FSM, 4-deep key FIFO.
// Optional feature macro: KEYPAD_AUTOREPEAT_EN (re-push a held key every REPEAT_SCANS scans).
module keypad_scan_ctrl #(
    parameter int SCAN_CYCLES    = 125_000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SCANS   = 250
) (
    input logic           clk,
    input logic           rst,
    keypad_scan_if.master bus
);
    localparam int DW_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int DB_W = $clog2(DEBOUNCE_SCANS + 1);

    typedef enum logic [1:0] {IDLE, CONFIRM, PRESSED, RELEASE} state_t;

    // Hex code printed on the key at row r, column c.
    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: key_map = 4'h1;  4'h1: key_map = 4'h2;  4'h2: key_map = 4'h3;  4'h3: key_map = 4'hA;
            4'h4: key_map = 4'h4;  4'h5: key_map = 4'h5;  4'h6: key_map = 4'h6;  4'h7: key_map = 4'hB;
            4'h8: key_map = 4'h7;  4'h9: key_map = 4'h8;  4'hA: key_map = 4'h9;  4'hB: key_map = 4'hC;
            4'hC: key_map = 4'h0;  4'hD: key_map = 4'hF;  4'hE: key_map = 4'hE;  default: key_map = 4'hD;
        endcase
    endfunction

    logic [3:0]      row_meta, row_sync;
    logic [DW_W-1:0] dwell_cnt;
    logic [1:0]      col_idx;
    logic            dwell_last, eval;
    logic [1:0]      hit_cnt;          // 0, 1, or 2 meaning "two or more" so far this scan
    logic [3:0]      hit_code;
    logic [2:0]      cur_cnt, tot_cnt;
    logic [1:0]      cur_row;
    logic [3:0]      scan_code;
    logic            res_none, res_key;

    state_t          state, state_nx;
    logic [3:0]      cand, cand_nx;
    logic [DB_W-1:0] cnt, cnt_nx;
    logic            push;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RP_W = $clog2(REPEAT_SCANS + 1);
    logic [RP_W-1:0] rep_cnt, rep_nx;
`else
    // Repeat interval has no meaning without auto-repeat; this empty guard only names it.
    if (REPEAT_SCANS < 1) begin : g_repeat_unused
    end
`endif

    logic [3:0] fifo_mem [0:3];
    logic [1:0] wr_ptr, rd_ptr;
    logic [2:0] count;
    logic       pop, full, do_push, ovf;

    // Two-flop synchroniser for the asynchronous row sense lines (idle = pulled high).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta <= '1;
            row_sync <= '1;
        end else begin
            row_meta <= bus.row_in;
            row_sync <= row_meta;
        end
    end

    assign dwell_last  = (dwell_cnt == DW_W'(SCAN_CYCLES - 1));
    assign eval        = dwell_last && (col_idx == 2'd3);
    assign bus.col_out = ~(4'b0001 << col_idx);

    // Column dwell timer and column pointer; one column low at a time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwell_cnt <= '0;
            col_idx   <= '0;
        end else if (dwell_last) begin
            dwell_cnt <= '0;
            col_idx   <= col_idx + 2'd1;
        end else begin
            dwell_cnt <= dwell_cnt + DW_W'(1);
        end
    end

    // Count low rows in the current column and fold them into the whole-scan tally.
    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    always_comb begin
        cur_cnt = '0;
        cur_row = '0;
        for (int r = 0; r < 4; r++) begin
            if (!row_sync[r]) begin
                cur_cnt = cur_cnt + 3'd1;
                cur_row = 2'(r);
            end
        end
        tot_cnt   = cur_cnt + 3'(hit_cnt);
        scan_code = (hit_cnt == 2'd1) ? hit_code : key_map(cur_row, col_idx);
        res_none  = eval && (tot_cnt == 3'd0);
        res_key   = eval && (tot_cnt == 3'd1);
    end

    // Per-scan intersection tally; cleared once column 3 has been evaluated.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt  <= '0;
            hit_code <= '0;
        end else if (dwell_last) begin
            if (col_idx == 2'd3) begin
                hit_cnt  <= '0;
                hit_code <= '0;
            end else begin
                hit_cnt  <= (tot_cnt >= 3'd2) ? 2'd2 : tot_cnt[1:0];
                hit_code <= scan_code;
            end
        end
    end

    // Debounce state, candidate key and scan counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cand    <= '0;
            cnt     <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt <= '0;
`endif
        end else begin
            state   <= state_nx;
            cand    <= cand_nx;
            cnt     <= cnt_nx;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt <= rep_nx;
`endif
        end
    end

    // Debounce decisions, taken only on the scan-result evaluation cycle.
    always_comb begin
        state_nx = state;
        cand_nx  = cand;
        cnt_nx   = cnt;
        push     = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_nx   = rep_cnt;
`endif
        if (eval) begin
            case (state)
                IDLE: begin
                    if (res_key) begin
                        state_nx = CONFIRM;
                        cand_nx  = scan_code;
                        cnt_nx   = DB_W'(1);
                    end
                end
                CONFIRM: begin
                    if (res_key && (scan_code == cand)) begin
                        if (cnt >= DB_W'(DEBOUNCE_SCANS - 1)) begin
                            push     = 1'b1;
                            state_nx = PRESSED;
`ifdef KEYPAD_AUTOREPEAT_EN
                            rep_nx   = '0;
`endif
                        end else begin
                            cnt_nx = cnt + DB_W'(1);
                        end
                    end else if (res_key) begin
                        cand_nx = scan_code;
                        cnt_nx  = DB_W'(1);
                    end else begin
                        state_nx = IDLE;
                    end
                end
                PRESSED: begin
                    if (res_none) begin
                        state_nx = RELEASE;
                        cnt_nx   = DB_W'(1);
                    end
`ifdef KEYPAD_AUTOREPEAT_EN
                    else if (res_key && (scan_code == cand)) begin
                        if (rep_cnt >= RP_W'(REPEAT_SCANS - 1)) begin
                            push   = 1'b1;
                            rep_nx = '0;
                        end else begin
                            rep_nx = rep_cnt + RP_W'(1);
                        end
                    end else begin
                        rep_nx = '0;
                    end
`endif
                end
                RELEASE: begin
                    if (res_none) begin
                        if (cnt >= DB_W'(DEBOUNCE_SCANS - 1)) state_nx = IDLE;
                        else                                   cnt_nx   = cnt + DB_W'(1);
                    end else begin
                        state_nx = PRESSED;
`ifdef KEYPAD_AUTOREPEAT_EN
                        rep_nx   = '0;
`endif
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    assign full    = (count == 3'd4);
    assign pop     = (count != 3'd0) && bus.key_ready;
    assign do_push = push && (!full || pop);

    // Key storage write port.
    // NOTE: storage is not reset; key_code is forced to 0 while empty so stale entries never show.
    always_ff @(posedge clk) begin
        if (do_push) fifo_mem[wr_ptr] <= cand;
    end

    // FIFO pointers, fill level and sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)     rd_ptr <= rd_ptr + 2'd1;
            if (do_push && !pop)      count <= count + 3'd1;
            else if (pop && !do_push) count <= count - 3'd1;
            if (push && full && !pop) ovf <= 1'b1;
        end
    end

    assign bus.key_valid  = (count != 3'd0);
    assign bus.key_code   = (count != 3'd0) ? fifo_mem[rd_ptr] : 4'h0;
    assign bus.fifo_count = count;
    assign bus.overflow   = ovf;
    assign bus.key_held   = (state == PRESSED) || (state == RELEASE);

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Self-checking bench for keypad_scan_ctrl: a behavioural keypad drives the matrix from a set of
// pressed keys, and a scan-level reference model predicts pushes, FIFO contents and flags.
module tb_keypad_scan_ctrl;
    localparam int SCAN_CYCLES    = 4;
    localparam int DEBOUNCE_SCANS = 2;
    localparam int REPEAT_SCANS   = 3;
    localparam int SCAN_LEN       = 4 * SCAN_CYCLES;

    // Key legend indexed by row*4 + column.
    localparam logic [3:0] KEYMAP [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                                           4'h7, 4'h8, 4'h9, 4'hC, 4'h0, 4'hF, 4'hE, 4'hD};

    typedef enum {M_IDLE, M_CONFIRM, M_PRESSED, M_RELEASE} mstate_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] keys = '0;
    int          checks = 0;
    int          errors = 0;

    mstate_t     m_state = M_IDLE;
    logic [3:0]  m_cand = '0;
    int          m_cnt = 0;
    int          m_rep = 0;
    logic [3:0]  mq[$];
    logic        m_ovf = 1'b0;

    keypad_scan_if kif ();

    keypad_scan_ctrl #(
        .SCAN_CYCLES   (SCAN_CYCLES),
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS),
        .REPEAT_SCANS  (REPEAT_SCANS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(kif)
    );

    always #5 clk = ~clk;

    // Passive keypad: a row reads low when a pressed key joins it to the driven-low column.
    always_comb begin
        kif.row_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4 + c] && !kif.col_out[c]) kif.row_in[r] = 1'b0;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_push(input logic [3:0] code);
        if (mq.size() < 4) mq.push_back(code);
        else               m_ovf = 1'b1;
    endtask

    // Reference: apply one whole-scan result to the debounce rules.
    task automatic model_scan(input logic [15:0] mask);
        int         n;
        logic [3:0] code;
        bit         none, is_key;
        n = $countones(mask);
        code = '0;
        for (int i = 0; i < 16; i++) if (mask[i]) code = KEYMAP[i];
        none   = (n == 0);
        is_key = (n == 1);
        case (m_state)
            M_IDLE:
                if (is_key) begin m_state = M_CONFIRM; m_cand = code; m_cnt = 1; end
            M_CONFIRM:
                if (is_key && code == m_cand) begin
                    m_cnt++;
                    if (m_cnt >= DEBOUNCE_SCANS) begin
                        model_push(m_cand);
                        m_state = M_PRESSED;
                        m_rep = 0;
                    end
                end else if (is_key) begin
                    m_cand = code; m_cnt = 1;
                end else m_state = M_IDLE;
            M_PRESSED:
                if (none) begin m_state = M_RELEASE; m_cnt = 1; end
`ifdef KEYPAD_AUTOREPEAT_EN
                else if (is_key && code == m_cand) begin
                    m_rep++;
                    if (m_rep >= REPEAT_SCANS) begin model_push(m_cand); m_rep = 0; end
                end else m_rep = 0;
`endif
            M_RELEASE:
                if (none) begin
                    m_cnt++;
                    if (m_cnt >= DEBOUNCE_SCANS) m_state = M_IDLE;
                end else begin
                    m_state = M_PRESSED; m_rep = 0;
                end
            default: m_state = M_IDLE;
        endcase
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "/col_out"},    8'(kif.col_out), 8'h0E);
        check({tag, "/key_valid"},  8'(kif.key_valid), 8'(mq.size() != 0));
        check({tag, "/key_code"},   8'(kif.key_code), 8'((mq.size() != 0) ? mq[0] : 4'h0));
        check({tag, "/fifo_count"}, 8'(kif.fifo_count), 8'(mq.size()));
        check({tag, "/key_held"},   8'(kif.key_held), 8'(m_state == M_PRESSED || m_state == M_RELEASE));
        check({tag, "/overflow"},   8'(kif.overflow), 8'(m_ovf));
    endtask

    // One full scan starting at column 0 (called at a negedge); pops in the first npops
    // cycles and, optionally, on the evaluation cycle itself.
    task automatic do_scan(input string tag, input logic [15:0] mask, input int npops, input bit pop_last);
        keys = mask;
        for (int i = 0; i < SCAN_LEN; i++) begin
            if (i == SCAN_LEN - 1) check({tag, "/valid_pre_eval"}, 8'(kif.key_valid), 8'(mq.size() != 0));
            if (i < npops || (pop_last && i == SCAN_LEN - 1)) begin
                if (mq.size() != 0) begin
                    check({tag, "/pop_head"}, 8'(kif.key_code), 8'(mq[0]));
                    void'(mq.pop_front());
                end
                kif.key_ready = 1'b1;
            end else begin
                kif.key_ready = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
        end
        kif.key_ready = 1'b0;
        model_scan(mask);
        check_outputs(tag);
    endtask

    task automatic press_release(input string tag, input int bit_idx);
        do_scan(tag, 16'(1) << bit_idx, 0, 1'b0);
        do_scan(tag, 16'(1) << bit_idx, 0, 1'b0);
        do_scan(tag, 16'h0, 0, 1'b0);
        do_scan(tag, 16'h0, 0, 1'b0);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "/col_out"},    8'(kif.col_out), 8'h0E);
        check({tag, "/key_valid"},  8'(kif.key_valid), 8'h00);
        check({tag, "/key_code"},   8'(kif.key_code), 8'h00);
        check({tag, "/fifo_count"}, 8'(kif.fifo_count), 8'h00);
        check({tag, "/key_held"},   8'(kif.key_held), 8'h00);
        check({tag, "/overflow"},   8'(kif.overflow), 8'h00);
    endtask

    initial begin
        logic [15:0] m;
        int          sel;
        kif.key_ready = 1'b0;

        // Power-on reset.
        repeat (3) @(negedge clk);
        reset_checks("por");
        rst = 1'b0;

        // Single key 6 (row1/col2): one push, 1-cycle latency, held until two NONE scans.
        do_scan("k6_s1", 16'h0040, 0, 1'b0);
        check("k6_s1_no_valid", 8'(kif.key_valid), 8'h00);
        do_scan("k6_s2", 16'h0040, 0, 1'b0);
        check("k6_s2_code", 8'(kif.key_code), 8'h06);
        do_scan("k6_s3", 16'h0040, 0, 1'b0);
        do_scan("k6_r1", 16'h0000, 0, 1'b0);
        check("k6_r1_held", 8'(kif.key_held), 8'h01);
        do_scan("k6_r2", 16'h0000, 0, 1'b0);
        check("k6_r2_held", 8'(kif.key_held), 8'h00);
        check("k6_count", 8'(kif.fifo_count), 8'h01);
        do_scan("k6_pop", 16'h0000, 1, 1'b0);

        // Bounce: key 5 alternating with nothing never gets accepted.
        for (int i = 0; i < 6; i++) do_scan("bounce", (i % 2 == 0) ? 16'h0020 : 16'h0000, 0, 1'b0);
        check("bounce_count", 8'(kif.fifo_count), 8'h00);

        // Two keys in one row: MULTI, no push; then only key 1 remains.
        for (int i = 0; i < 3; i++) do_scan("multi", 16'h0003, 0, 1'b0);
        check("multi_held", 8'(kif.key_held), 8'h00);
        do_scan("multi_k1a", 16'h0001, 0, 1'b0);
        do_scan("multi_k1b", 16'h0001, 0, 1'b0);
        check("multi_k1_code", 8'(kif.key_code), 8'h01);
        do_scan("multi_rel", 16'h0000, 0, 1'b0);
        do_scan("multi_rel", 16'h0000, 1, 1'b0);

        // Full FIFO with a pop on the push cycle: no overflow, new key lands at the tail.
        press_release("fill_1", 0);
        press_release("fill_2", 1);
        press_release("fill_3", 2);
        press_release("fill_a", 3);
        do_scan("fullpp_s1", 16'h0010, 0, 1'b0);
        do_scan("fullpp_s2", 16'h0010, 0, 1'b1);
        check("fullpp_count", 8'(kif.fifo_count), 8'h04);
        check("fullpp_ovf", 8'(kif.overflow), 8'h00);
        do_scan("fullpp_rel", 16'h0000, 0, 1'b0);
        do_scan("fullpp_drain", 16'h0000, 4, 1'b0);

        // Five keys with no consumer: the fifth is dropped and overflow sticks.
        press_release("ovf_1", 0);
        press_release("ovf_2", 1);
        press_release("ovf_3", 2);
        press_release("ovf_a", 3);
        press_release("ovf_4", 4);
        check("ovf_count", 8'(kif.fifo_count), 8'h04);
        check("ovf_flag", 8'(kif.overflow), 8'h01);
        do_scan("ovf_drain", 16'h0000, 4, 1'b0);
        check("ovf_sticky", 8'(kif.overflow), 8'h01);

        // Reset while a key is held with two entries queued.
        press_release("rst_q1", 8);
        do_scan("rst_q2", 16'h0200, 0, 1'b0);
        do_scan("rst_q2", 16'h0200, 0, 1'b0);
        check("rst_pre_count", 8'(kif.fifo_count), 8'h02);
        repeat (5) begin @(posedge clk); @(negedge clk); end
        rst = 1'b1;
        keys = '0;
        #1;
        reset_checks("midrst");
        @(negedge clk);
        rst = 1'b0;
        m_state = M_IDLE;
        mq.delete();
        m_ovf = 1'b0;
        do_scan("post_rst", 16'h0000, 0, 1'b0);

        // Hold D for 8 scans: one push, or three with auto-repeat.
        for (int i = 0; i < 8; i++) do_scan("hold_d", 16'h8000, 0, 1'b0);
`ifdef KEYPAD_AUTOREPEAT_EN
        check("hold_d_count", 8'(kif.fifo_count), 8'h03);
`else
        check("hold_d_count", 8'(kif.fifo_count), 8'h01);
`endif
        do_scan("hold_d_rel", 16'h0000, 0, 1'b0);
        do_scan("hold_d_drain", 16'h0000, 3, 1'b0);

        // Randomised key activity against the reference model.
        m = '0;
        for (int s = 0; s < 80; s++) begin
            sel = int'($urandom_range(0, 7));
            if (sel == 3 || sel == 4)      m = '0;
            else if (sel == 5 || sel == 6) m = 16'(1) << $urandom_range(0, 15);
            else if (sel == 7)             m = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
            do_scan("rand", m, int'($urandom_range(0, 2)), ($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/keypad_scan_ctrl.md
KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 Parameter SCAN_CYCLES, default 125_000, clock cycles each column is driven (1 ms at 125 MHz).
REQ-002 Parameter DEBOUNCE_SCANS, default 4, consecutive identical full scans needed to accept a press or a release.
REQ-003 Parameter REPEAT_SCANS, default 250, full scans between auto-repeat pushes (used only under KEYPAD_AUTOREPEAT_EN).
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 col_out  output  4  column drive, active-low, exactly one bit low at all times.
REQ-007 row_in  input  4  row sense, active-low (pulled up externally), asynchronous to clk.
REQ-008 key_code  output  4  hex code of the FIFO head entry.
REQ-009 key_valid  output  1  FIFO non-empty; key_code is valid.
REQ-010 key_ready  input  1  consumer accepts the head entry when key_valid is high.
REQ-011 key_held  output  1  high while the state machine is in PRESSED or RELEASE.
REQ-012 fifo_count  output  3  number of FIFO entries, 0..4.
REQ-013 overflow  output  1  sticky flag: a key was dropped because the FIFO was full.

Function
REQ-014 row_in SHALL pass through a 2-flop synchroniser before any use.
REQ-015 Scan: col_out SHALL step 1110 -> 1101 -> 1011 -> 0111 -> 1110, changing every SCAN_CYCLES cycles; rows SHALL be sampled on the last cycle of each column dwell.
REQ-016 Key map (row r, column c): r0 = 1,2,3,A; r1 = 4,5,6,B; r2 = 7,8,9,C; r3 = 0,F,E,D.
REQ-017 Scan result, evaluated after column 3 is sampled: NONE if no row low in any column; KEY(code) if exactly one row/column intersection is low; MULTI otherwise.
REQ-018 States: IDLE, CONFIRM, PRESSED, RELEASE; transitions occur only at scan-result evaluation.
REQ-019 IDLE: KEY(k) -> CONFIRM with candidate = k and match count = 1; NONE and MULTI stay in IDLE.
REQ-020 CONFIRM: KEY(candidate) increments the count; when the count reaches DEBOUNCE_SCANS, push the candidate and go to PRESSED. KEY(other) restarts CONFIRM with the new candidate and count 1. NONE or MULTI -> IDLE.
REQ-021 PRESSED: NONE -> RELEASE with release count = 1; KEY(candidate) and MULTI stay in PRESSED.
REQ-022 RELEASE: NONE increments the count; when it reaches DEBOUNCE_SCANS -> IDLE. Any KEY or MULTI -> PRESSED, with no new push.
REQ-023 FIFO: depth 4, first-in first-out; key_code = head entry; pop when key_valid && key_ready.
REQ-024 A push while full without a same-cycle pop SHALL drop the new key, set overflow, and leave the contents unchanged.
REQ-025 A push and a pop in the same cycle SHALL both take effect at any fill level, including full; fifo_count stays unchanged.
REQ-026 key_ready while empty SHALL have no effect.
REQ-027 Push-to-key_valid latency SHALL be 1 cycle from the evaluation cycle.

Reset
REQ-028 On rst: col_out = 1110, scan/dwell counters = 0, state = IDLE, FIFO empty, key_valid = 0, key_code = 0, fifo_count = 0, key_held = 0, overflow = 0.
REQ-029 Reset mid-scan or mid-press SHALL discard the candidate and all FIFO contents; scanning restarts at column 0 on the first cycle after rst deasserts.
REQ-030 overflow SHALL clear only on rst.

Configuration
REQ-031 Macro KEYPAD_AUTOREPEAT_EN. When defined, every REPEAT_SCANS consecutive KEY(candidate) results in PRESSED push the candidate again; the repeat counter resets on entry to PRESSED and on every RELEASE -> PRESSED return.
REQ-032 When not defined, the repeat logic is absent and REPEAT_SCANS is ignored; exactly one push occurs per accepted press.

Verification (SCAN_CYCLES=4, DEBOUNCE_SCANS=2, REPEAT_SCANS=3)
REQ-033 Hold row1/col2 low for 3 scans, then release -> exactly one entry 0x6 is pushed, key_valid rises 1 cycle after the 2nd matching scan, and key_held falls after 2 NONE scans.
REQ-034 Press 5 keys 1,2,3,A,4 with key_ready=0 -> fifo_count=4, overflow=1, pops return 1,2,3,A in order.
REQ-035 Hold row0/col0 and row0/col1 together -> MULTI, no push, state stays IDLE; releasing col1 -> 0x1 accepted after 2 scans.
REQ-036 Bounce: a key alternately low/high on successive scans -> no push, fifo_count=0.
REQ-037 FIFO full, key_ready=1 in the same cycle as a push -> fifo_count stays 4, overflow stays 0, and the new key is at the tail.
REQ-038 Assert rst in PRESSED with 2 entries queued -> key_valid=0, fifo_count=0, col_out=1110; with KEYPAD_AUTOREPEAT_EN, holding 0xD for 8 scans yields 0xD,0xD,0xD.
